// File: rtl/wsn_radio_pkg.sv
// wsn_radio_pkg: shared radio framing types, constants and checksum helper
package wsn_radio_pkg;
  typedef enum logic [2:0] {IDLE, FILL, SYNC, ID, LEN, PAYLOAD, CSUM} tx_state_t;
  localparam int HDR_BYTES = 3;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
endpackage

// File: rtl/tx_payload_buf.sv
// tx_payload_buf: payload byte store, sync write, combinational read, no reset
module tx_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/radio_tx_framer.sv
// radio_tx_framer: buffers a payload burst and streams it as a SYNC/ID/LEN/payload/XOR frame
module radio_tx_framer import wsn_radio_pkg::*; #(
  parameter int         MAX_PAYLOAD = 16,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [7:0] NODE_ID     = 8'h01
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic       radio_busy,
  output logic [7:0] radio_data_out,
  output logic       radio_send,
  output logic       radio_enable,
  output logic       frame_done,
  output logic       truncated
);
  localparam int AW = $clog2(MAX_PAYLOAD);
  localparam logic [7:0] LAST_IDX = 8'(MAX_PAYLOAD - 1);
  tx_state_t state, state_nx;
  logic [7:0] cnt, rd_ptr, csum, rd_data;
  logic take, acc;
  assign in_ready = rst_n && (state == IDLE || state == FILL);
  assign take = in_valid && in_ready;
  assign radio_send = state inside {SYNC, ID, LEN, PAYLOAD, CSUM};
  assign radio_enable = radio_send;
  assign acc = radio_send && !radio_busy;
  assign frame_done = state == CSUM && acc;
  assign truncated = state == FILL && take && !in_last && cnt == LAST_IDX;
  tx_payload_buf #(.DEPTH(MAX_PAYLOAD), .AW(AW)) u_buf (
    .clk  (clk),
    .we   (take),
    .waddr(cnt[AW-1:0]),
    .wdata(in_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rd_data)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = in_last ? SYNC : FILL;
      FILL:    if (take && (in_last || cnt == LAST_IDX)) state_nx = SYNC;
      SYNC:    if (acc) state_nx = ID;
      ID:      if (acc) state_nx = LEN;
      LEN:     if (acc) state_nx = PAYLOAD;
      PAYLOAD: if (acc && rd_ptr == cnt - 8'd1) state_nx = CSUM;
      CSUM:    if (acc) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    radio_data_out = state == SYNC    ? SYNC_BYTE :
                     state == ID      ? NODE_ID   :
                     state == LEN     ? cnt       :
                     state == PAYLOAD ? rd_data   :
                     state == CSUM    ? csum      : 8'h00;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      rd_ptr <= 8'd0;
      csum   <= 8'd0;
    end else begin
      state <= state_nx;
      if (take) cnt <= cnt + 8'd1;
      if (state == ID && acc) csum <= NODE_ID;
      if (state == LEN && acc) csum <= xor8(csum, cnt);
      if (state == PAYLOAD && acc) begin
        csum   <= xor8(csum, rd_data);
        rd_ptr <= rd_ptr + 8'd1;
      end
      if (frame_done) begin
        cnt    <= 8'd0;
        rd_ptr <= 8'd0;
        csum   <= 8'd0;
      end
    end
  end
endmodule
